// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment vectors are ordered abcdefg, active-low.
package sseg_pkg;

    localparam logic [0:6] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    localparam logic [0:6] SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

endpackage

// File: rtl/hex7seg_dec.sv
// Hex nibble to active-low abcdefg segment pattern.
// Purely combinational lookup into the shared table.
module hex7seg_dec
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [0:6] seg
);

    assign seg = SEG_HEX[hex];

endmodule

// File: rtl/sseg_scan_driver.sv
// 4-digit common-anode scan driver with frame-synchronised shadow data.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic [0:6]  sseg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(BLANK_CYC + 1);

    state_t        state, stateNext;
    logic [1:0]    idx, idxNext;
    logic [PW-1:0] prescaler;
    logic [BW-1:0] bcnt, bcntNext;
    logic [15:0]   shadow, shadowNext;
    logic [15:0]   pending;
    logic          pendV;
    logic          tick, wrap;
    logic [3:0]    nibble;
    logic [0:6]    decSeg;
    logic          blankDigit;
    logic [3:0]    anNext;
    logic [0:6]    segNext;

    assign tick   = (prescaler == PW'(CLK_DIV - 1));
    assign wrap   = tick && (idx == 2'd3);
    assign nibble = shadowNext[{idxNext, 2'b00} +: 4];

    hex7seg_dec uDec (
        .hex (nibble),
        .seg (decSeg)
    );

    always_comb begin
        stateNext  = state;
        idxNext    = idx;
        bcntNext   = bcnt;
        shadowNext = shadow;
        if (tick) begin
            idxNext   = idx + 2'd1;
            stateNext = BLANK;
            bcntNext  = '0;
        end else begin
            unique case (state)
                BLANK: begin
                    if (bcnt == BW'(BLANK_CYC - 1)) stateNext = DRIVE;
                    else bcntNext = bcnt + BW'(1);
                end
                DRIVE: ;
            endcase
        end
        // A load on the wrap cycle itself takes effect this frame.
        if (wrap) begin
            if (load)       shadowNext = data_in;
            else if (pendV) shadowNext = pending;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blankDigit = (idxNext != 2'd0)
                     && ((shadowNext >> {idxNext, 2'b00}) == 16'h0000);
`else
    assign blankDigit = 1'b0;
`endif

    always_comb begin
        anNext  = AN_OFF;
        segNext = SEG_OFF;
        if (stateNext == DRIVE) begin
            anNext  = ~(4'b0001 << idxNext);
            segNext = blankDigit ? SEG_OFF : decSeg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BLANK;
            idx        <= 2'd0;
            prescaler  <= '0;
            bcnt       <= '0;
            shadow     <= 16'h0000;
            pending    <= 16'h0000;
            pendV      <= 1'b0;
            sseg       <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= stateNext;
            idx        <= idxNext;
            bcnt       <= bcntNext;
            shadow     <= shadowNext;
            prescaler  <= tick ? '0 : prescaler + PW'(1);
            sseg       <= segNext;
            an         <= anNext;
            frame_done <= wrap;
            if (wrap) begin
                pendV <= 1'b0;
            end else if (load) begin
                pending <= data_in;
                pendV   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Downstream display stage for the register-bank lab top.
- Takes four 4-bit register read values, packed into 16 bits, and time-multiplexes them onto a 4-digit common-anode seven-segment display.
- Contains a refresh prescaler, a per-digit blanking/drive FSM and a frame-synchronised shadow register, so that register writes never tear a frame.
- Outputs go straight to the board pins sseg/an.

Parameters:
- CLK_DIV, 50000: clk cycles per digit slot (1 kHz slot rate at 50 MHz); legal range ≥ 2.
- BLANK_CYC, 500: anti-ghosting dead cycles at the start of each slot; legal range 1 ≤ BLANK_CYC < CLK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  16  nibble k = data_in[4k+3:4k] is shown on digit k.
- load  in  1  one-cycle strobe; captures data_in.
- sseg  out  [0:6]  segments a..g, with sseg[0]=a; active-low; registered.
- an  out  4  digit anodes, with an[k] = digit k; active-low; registered.
- frame_done  out  1  one-cycle pulse when the digit index wraps 3→0.

Behaviour:
- Reset (rst=0, async): state=BLANK, idx=0, prescaler=0, bcnt=0, shadow=16'h0000, pend_v=0; sseg=7'b1111111, an=4'b1111, frame_done=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick is asserted when prescaler==CLK_DIV-1.
- FSM, two states:
  - BLANK: an=1111, sseg=1111111. bcnt increments each cycle; when bcnt==BLANK_CYC-1, go to DRIVE.
  - DRIVE: an = ~(4'b0001<<idx), sseg=decode(shadow nibble idx).
  - On tick from either state: idx<=idx+1 mod 4, state<=BLANK, bcnt<=0.
- Slot timing:
  - Outputs are registered on the same edge as the state update.
  - Per slot: exactly BLANK_CYC cycles with an=1111, then CLK_DIV-BLANK_CYC cycles with one anode low.
  - Slot length is CLK_DIV cycles; frame length is 4·CLK_DIV cycles.
  - The first slot after reset shows digit 0.
- Load and shadow:
  - load=1 sets pending<=data_in and pend_v<=1. A later load overwrites pending (last wins).
  - At the wrap tick (idx 3→0): if load is high that same cycle, shadow<=data_in; otherwise, if pend_v=1, shadow<=pending. In both cases pend_v<=0.
  - Shadow never changes mid-frame.
- frame_done: high for exactly the one cycle following the wrap tick edge.
- Decode (hex, active-low, order abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Reset mid-slot: outputs blank immediately (async); the scan restarts at digit 0 after release; pending data is discarded.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: in DRIVE, a digit k>0 is forced to sseg=1111111 when nibbles k..3 of shadow are all zero. The anode is still driven, so slot timing is unchanged. Digit 0 is never suppressed.
- Undefined: all four digits always show their hex value.

Decomposition:
- Package sseg_pkg holds:
  - the 16-entry SEG_HEX constant table;
  - SEG_OFF=7'b1111111 and AN_OFF=4'b1111;
  - the state enum {BLANK, DRIVE}.
- One combinational sub-module, hex7seg_dec (4-bit in, [0:6] out), wraps SEG_HEX. The scan FSM, prescaler and shadow logic stay in sseg_scan_driver.

Test Plan (CLK_DIV=8, BLANK_CYC=2):
- Reset, pulse load with data_in=16'h3210, run 2 frames → from frame 2 onward, each 8-cycle slot is 2 cycles an=1111 then 6 cycles with an=1110/1101/1011/0111 and sseg=0000001/1001111/0010010/0000110.
- Load 16'hABCD when idx=1 → the current frame keeps the old value; the next frame shows D,C,b,A (0000110→1000010, 0110001, 1100000, 0001000); frame_done pulses once per 32 cycles.
- Load 16'h1111 then 16'h2222 in the same frame → the next frame shows only 2s (0010010).
- load coincident with the wrap tick, data 16'hF0F0 → that frame shows digits F,0,F,0 with no one-frame delay.
- Assert rst low mid-DRIVE for 3 cycles → sseg/an go to all-ones within the same cycle; after release the first slot is digit 0, starting with 2 blank cycles.
- With LEADING_ZERO_BLANK_EN defined, data 16'h0050 → digits 3 and 2 show sseg=1111111 with an low; digit 1 shows 5 (0100100); digit 0 shows 0.
